// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the core-to-bus data bridge.
// Build option: DMEM_BRIDGE_POSTED_WR_EN (see dmem_bus_bridge).
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } bridge_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unlisted funct3 encodings behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return addr_lo[0];
      default:     return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte enables, write replication, load extraction
// and misalignment detection for one data access.
module dmem_lane_align
  import dmem_bridge_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] w_byte_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_shift = i_rdata_raw >> {i_addr_lo, 3'b000};
  assign w_byte       = w_byte_shift[7:0];
  assign w_half       = i_addr_lo[1] ? i_rdata_raw[31:16] : i_rdata_raw[15:0];
  assign o_misaligned = is_misaligned(i_funct3, i_addr_lo);

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata_raw;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      F3_H, F3_HU: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Turns single-cycle core loads/stores into one valid/ready bus transaction, stalling the core
// until completion. Build option: DMEM_BRIDGE_POSTED_WR_EN enables posted (fire-and-forget) stores.
module dmem_bus_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_core_re,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [31:0]       i_core_wdata,
  input  logic [2:0]        i_core_funct3,
  output logic [31:0]       o_core_rdata,
  output logic              o_core_stall,
  output logic              o_core_fault,
  output logic              o_bus_req_valid,
  input  logic              i_bus_req_ready,
  output logic              o_bus_req_we,
  output logic [ADDR_W-1:0] o_bus_req_addr,
  output logic [31:0]       o_bus_req_wdata,
  output logic [3:0]        o_bus_req_be,
  input  logic              i_bus_resp_valid,
  input  logic [31:0]       i_bus_resp_data,
  input  logic              i_bus_resp_err
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  bridge_state_e     r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [31:0]       r_wdata, w_wdata_d;
  logic [31:0]       r_rdata, w_rdata_d;
  logic [3:0]        r_be, w_be_d;
  logic [2:0]        r_funct3, w_funct3_d;
  logic              r_we, w_we_d;
  logic              r_fault, w_fault_d;
  logic [15:0]       r_cnt, w_cnt_d;

  logic              w_idle, w_access, w_timeout;
  logic              w_posted, w_wr_block, w_post_fault;
  logic [2:0]        w_la_funct3;
  logic [1:0]        w_la_addr;
  logic [3:0]        w_la_be;
  logic [31:0]       w_la_wdata, w_la_rdata;
  logic              w_la_mis;

  assign w_idle    = r_state == StIdle;
  assign w_access  = i_core_re | i_core_we;
  assign w_timeout = (r_cnt + 16'd1) == TIMEOUT_CNT;

  // Lane logic sees the live core access in IDLE and the captured access afterwards.
  assign w_la_funct3 = w_idle ? i_core_funct3 : r_funct3;
  assign w_la_addr   = w_idle ? i_core_addr[1:0] : r_addr[1:0];

  dmem_lane_align u_lane_align (
    .i_funct3     (w_la_funct3),
    .i_addr_lo    (w_la_addr),
    .i_wdata      (i_core_wdata),
    .i_rdata_raw  (i_bus_resp_data),
    .o_be         (w_la_be),
    .o_wdata      (w_la_wdata),
    .o_rdata      (w_la_rdata),
    .o_misaligned (w_la_mis)
  );

`ifdef DMEM_BRIDGE_POSTED_WR_EN
  logic r_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == StReq && i_bus_req_ready && r_we) begin
      r_pending <= 1'b1;
    end else if (r_pending && (i_bus_resp_valid || w_timeout)) begin
      r_pending <= 1'b0;
    end
  end

  assign w_posted     = 1'b1;
  assign w_wr_block   = r_pending;
  assign w_post_fault = r_pending & (i_bus_resp_valid ? i_bus_resp_err : w_timeout);
`else
  assign w_posted     = 1'b0;
  assign w_wr_block   = 1'b0;
  assign w_post_fault = 1'b0;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_addr_d   = r_addr;
    w_wdata_d  = r_wdata;
    w_rdata_d  = r_rdata;
    w_be_d     = r_be;
    w_funct3_d = r_funct3;
    w_we_d     = r_we;
    w_fault_d  = r_fault;
    w_cnt_d    = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_access && !w_la_mis && !w_wr_block) begin
          w_state_d  = StReq;
          w_addr_d   = i_core_addr;
          w_funct3_d = i_core_funct3;
          w_we_d     = i_core_we;
          w_be_d     = w_la_be;
          w_wdata_d  = w_la_wdata;
          w_rdata_d  = 32'd0;
          w_fault_d  = 1'b0;
        end
      end
      StReq: begin
        if (i_bus_req_ready) begin
          w_cnt_d   = 16'd0;
          w_state_d = (w_posted && r_we) ? StDone : StWait;
        end
      end
      StWait: begin
        w_cnt_d = r_cnt + 16'd1;
        if (i_bus_resp_valid) begin
          w_state_d = StDone;
          w_rdata_d = i_bus_resp_err ? 32'd0 : w_la_rdata;
          w_fault_d = i_bus_resp_err;
        end else if (w_timeout) begin
          w_state_d = StDone;
          w_rdata_d = 32'd0;
          w_fault_d = 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // An outstanding posted write ages on the same counter; it never overlaps REQ/WAIT.
    if (w_wr_block) w_cnt_d = r_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_be     <= 4'd0;
      r_funct3 <= 3'd0;
      r_we     <= 1'b0;
      r_fault  <= 1'b0;
      r_cnt    <= 16'd0;
    end else begin
      r_state  <= w_state_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_rdata  <= w_rdata_d;
      r_be     <= w_be_d;
      r_funct3 <= w_funct3_d;
      r_we     <= w_we_d;
      r_fault  <= w_fault_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign o_core_stall    = (r_state == StReq) | (r_state == StWait) |
                           (w_idle & w_access & ~w_la_mis);
  assign o_core_fault    = (w_idle & w_access & w_la_mis) | ((r_state == StDone) & r_fault) |
                           w_post_fault;
  assign o_core_rdata    = (r_state == StDone) ? r_rdata : 32'd0;
  assign o_bus_req_valid = r_state == StReq;
  assign o_bus_req_we    = r_we;
  assign o_bus_req_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_bus_req_wdata = r_wdata;
  assign o_bus_req_be    = r_be;

endmodule
